// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an asynchronous FIFO: write-pointer synchronizer,
// read pointer and empty/count flags, and a one-entry registered
// first-word-fall-through output stage with a valid/ready handshake.
module fifo_rd_ctrl #(
    parameter int unsigned DATA_SIZE = 4,
    parameter int unsigned ADDR_SIZE = 4
) (
    input  logic                 rd_clk,
    input  logic                 rd_rst_n,
    input  logic [ADDR_SIZE:0]   wr_ptr_gray,
    output logic [ADDR_SIZE-1:0] rd_addr,
    input  logic [DATA_SIZE-1:0] mem_rd_data,
    output logic [ADDR_SIZE:0]   rd_ptr_gray,
    output logic                 rd_empty,
    output logic [ADDR_SIZE:0]   rd_count,
    output logic [DATA_SIZE-1:0] rd_data,
    output logic                 rd_valid,
    input  logic                 rd_ready
);

    localparam int unsigned PW = ADDR_SIZE + 1;

    logic [PW-1:0] wq1;
    logic [PW-1:0] wq2;
    logic [PW-1:0] rbin;
    logic [PW-1:0] rgray;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_next;
    logic [PW-1:0] wbin;
    logic          fetch;

    assign rd_addr     = rbin[ADDR_SIZE-1:0];
    assign rd_ptr_gray = rgray;

    // Fetch decision, next read pointer and binary form of the synced write pointer
    always_comb begin
        fetch      = !rd_empty && (!rd_valid || rd_ready);
        rbin_next  = rbin + PW'(fetch);
        rgray_next = rbin_next ^ (rbin_next >> 1);
        wbin       = '0;
        for (int unsigned i = 0; i < PW; i++) begin
            wbin[i] = ^(wq2 >> i);
        end
    end

    // Two-flop synchronizer for the write-domain Gray pointer
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            wq1 <= '0;
            wq2 <= '0;
        end else begin
            wq1 <= wr_ptr_gray;
            wq2 <= wq1;
        end
    end

    // Read pointer, empty flag and occupancy count
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            rbin     <= '0;
            rgray    <= '0;
            rd_empty <= 1'b1;
            rd_count <= '0;
        end else begin
            rbin     <= rbin_next;
            rgray    <= rgray_next;
            rd_empty <= (rgray_next == wq2);
            rd_count <= wbin - rbin_next;
        end
    end

    // Output stage: load on fetch, drop valid on an accept with nothing to refill
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (fetch) begin
            rd_data  <= mem_rd_data;
            rd_valid <= 1'b1;
        end else if (rd_valid && rd_ready) begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: the bench plays the write side and the
// FIFO memory, and checks reset, latency, bursts, backpressure, wrap and
// mid-burst reset against hand-derived values.
module tb_fifo_rd_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] wr_ptr_gray;
    logic [3:0] rd_addr;
    logic [7:0] mem_rd_data;
    logic [4:0] rd_ptr_gray;
    logic       rd_empty;
    logic [4:0] rd_count;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;

    logic [7:0] mem [16];
    logic [4:0] wptr;

    int pass_cnt;
    int total;

    logic       v0;
    logic       r0;
    logic [7:0] d0;
    logic [3:0] a0;
    logic [4:0] g0;
    int         n;
    int         written;
    bit         saw_g;
    bit         saw_a;
    logic [3:0] pat;

    fifo_rd_ctrl #(.DATA_SIZE(8), .ADDR_SIZE(4)) dut (
        .rd_clk      (clk),
        .rd_rst_n    (rst_n),
        .wr_ptr_gray (wr_ptr_gray),
        .rd_addr     (rd_addr),
        .mem_rd_data (mem_rd_data),
        .rd_ptr_gray (rd_ptr_gray),
        .rd_empty    (rd_empty),
        .rd_count    (rd_count),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready)
    );

    assign mem_rd_data = mem[rd_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] to_gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_wptr(input logic [4:0] b);
        wptr        = b;
        wr_ptr_gray = to_gray(b);
    endtask

    initial begin
        pass_cnt = 0;
        total    = 0;
        rst_n    = 1'b1;
        rd_ready = 1'b0;
        pat      = 4'b1001;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        set_wptr(5'd0);

        // Reset asserted between edges must act immediately
        #7;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_empty", 32'(rd_empty), 32'd1);
        chk("rst_count", 32'(rd_count), 32'd0);
        chk("rst_data",  32'(rd_data),  32'd0);
        chk("rst_addr",  32'(rd_addr),  32'd0);
        chk("rst_gray",  32'(rd_ptr_gray), 32'd0);
        tick;
        tick;
        rst_n = 1'b1;

        // Single word with the consumer stalled
        mem[0] = 8'hA5;
        set_wptr(5'd1);
        tick;                                   // E0
        chk("sw_e0_empty", 32'(rd_empty), 32'd1);
        tick;                                   // E1
        chk("sw_e1_empty", 32'(rd_empty), 32'd1);
        tick;                                   // E2
        chk("sw_e2_empty", 32'(rd_empty), 32'd0);
        chk("sw_e2_count", 32'(rd_count), 32'd1);
        chk("sw_e2_valid", 32'(rd_valid), 32'd0);
        tick;                                   // E3
        chk("sw_e3_valid", 32'(rd_valid), 32'd1);
        chk("sw_e3_data",  32'(rd_data),  32'hA5);
        chk("sw_e3_addr",  32'(rd_addr),  32'd1);
        chk("sw_e3_gray",  32'(rd_ptr_gray), 32'd1);
        chk("sw_e3_empty", 32'(rd_empty), 32'd1);
        chk("sw_e3_count", 32'(rd_count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("sw_hold_valid", 32'(rd_valid), 32'd1);
            chk("sw_hold_data",  32'(rd_data),  32'hA5);
        end
        rd_ready = 1'b1;
        tick;
        chk("sw_accept_valid", 32'(rd_valid), 32'd0);
        chk("sw_accept_addr",  32'(rd_addr),  32'd1);
        rd_ready = 1'b0;

        // Full burst of 16 words from a fresh reset
        rst_n = 1'b0;
        set_wptr(5'd0);
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = 8'(i);
        rd_ready = 1'b1;
        set_wptr(5'd16);
        tick;
        tick;
        tick;                                   // E2
        chk("fb_e2_count", 32'(rd_count), 32'd16);
        chk("fb_e2_empty", 32'(rd_empty), 32'd0);
        for (int k = 0; k < 16; k++) begin
            tick;
            chk("fb_valid", 32'(rd_valid), 32'd1);
            chk("fb_data",  32'(rd_data),  32'(k));
        end
        tick;
        chk("fb_end_valid", 32'(rd_valid), 32'd0);
        chk("fb_end_empty", 32'(rd_empty), 32'd1);
        chk("fb_end_count", 32'(rd_count), 32'd0);
        chk("fb_end_gray",  32'(rd_ptr_gray), 32'b11000);

        // Backpressure: ready pattern 1,0,0,1 over 8 words at rbin 16..23
        for (int i = 0; i < 8; i++) mem[i] = 8'(8'h40 + i);
        set_wptr(5'd24);
        n = 0;
        for (int c = 0; c < 80 && n < 8; c++) begin
            rd_ready = pat[c % 4];
            v0 = rd_valid;
            r0 = rd_ready;
            d0 = rd_data;
            a0 = rd_addr;
            tick;
            if (v0 && r0) begin
                chk("bp_data", 32'(d0), 32'(8'h40 + n));
                n++;
            end else if (v0) begin
                chk("bp_stable_data", 32'(rd_data), 32'(d0));
                chk("bp_stable_addr", 32'(rd_addr), 32'(a0));
            end
        end
        chk("bp_count", 32'(n), 32'd8);
        chk("bp_end_valid", 32'(rd_valid), 32'd0);
        chk("bp_end_empty", 32'(rd_empty), 32'd1);

        // Wrap: 40 words streamed from rbin 24 through 31->0 to 0 again
        n       = 0;
        written = 0;
        saw_g   = 1'b0;
        saw_a   = 1'b0;
        for (int c = 0; c < 400 && n < 40; c++) begin
            if (written < 40 && (written - n) < 16) begin
                mem[(8 + written) % 16] = 8'(8'h80 + written);
                set_wptr(wptr + 5'd1);
                written++;
            end
            rd_ready = (c % 5 != 3);
            v0 = rd_valid;
            r0 = rd_ready;
            d0 = rd_data;
            a0 = rd_addr;
            g0 = rd_ptr_gray;
            tick;
            if (v0 && r0) begin
                chk("wr_data", 32'(d0), 32'(8'h80 + n));
                n++;
            end
            if (g0 == 5'b10000 && rd_ptr_gray == 5'b00000) saw_g = 1'b1;
            if (a0 == 4'd15 && rd_addr == 4'd0) saw_a = 1'b1;
            chk("wr_gray_step", 32'($countones(g0 ^ rd_ptr_gray) <= 1), 32'd1);
        end
        chk("wr_count",     32'(n),     32'd40);
        chk("wr_gray_wrap", 32'(saw_g), 32'd1);
        chk("wr_addr_wrap", 32'(saw_a), 32'd1);
        chk("wr_end_gray",  32'(rd_ptr_gray), 32'd0);
        chk("wr_end_empty", 32'(rd_empty), 32'd1);
        chk("wr_end_valid", 32'(rd_valid), 32'd0);

        // Reset mid-burst: one word staged, five still in memory
        rd_ready = 1'b0;
        for (int i = 0; i < 6; i++) mem[i] = 8'(8'hC0 + i);
        set_wptr(5'd6);
        tick;
        tick;
        tick;
        tick;                                   // E3
        chk("mb_valid", 32'(rd_valid), 32'd1);
        chk("mb_data",  32'(rd_data),  32'hC0);
        chk("mb_count", 32'(rd_count), 32'd5);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mb_rst_valid", 32'(rd_valid), 32'd0);
        chk("mb_rst_empty", 32'(rd_empty), 32'd1);
        chk("mb_rst_count", 32'(rd_count), 32'd0);
        chk("mb_rst_data",  32'(rd_data),  32'd0);
        chk("mb_rst_addr",  32'(rd_addr),  32'd0);
        chk("mb_rst_gray",  32'(rd_ptr_gray), 32'd0);
        set_wptr(5'd0);
        tick;
        tick;
        rst_n = 1'b1;
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("mb_post_valid", 32'(rd_valid), 32'd0);
            chk("mb_post_empty", 32'(rd_empty), 32'd1);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side controller for the N-bit asynchronous FIFO. Runs entirely in the read clock domain. It synchronizes the write-domain Gray pointer, maintains the read pointer, and generates the empty flag and memory read address. It presents memory data through a one-entry registered first-word-fall-through output stage with a valid/ready handshake. It drives the combinational read port of the FIFO memory and returns its Gray read pointer to the write-domain full logic.

## Interface
- DATA_SIZE, 4, width of a FIFO word
- ADDR_SIZE, 4, memory address width; depth = 2^ADDR_SIZE; pointers are ADDR_SIZE+1 bits

- rd_clk  in  1  read-domain clock
- rd_rst_n  in  1  reset, asynchronous, active-low
- wr_ptr_gray  in  ADDR_SIZE+1  Gray write pointer from the write domain (asynchronous to rd_clk)
- rd_addr  out  ADDR_SIZE  memory read address = low ADDR_SIZE bits of binary read pointer
- mem_rd_data  in  DATA_SIZE  combinational memory output for rd_addr
- rd_ptr_gray  out  ADDR_SIZE+1  registered Gray read pointer, to write-domain synchronizer
- rd_empty  out  1  registered; memory holds no unread word (output stage excluded)
- rd_count  out  ADDR_SIZE+1  registered count of words in memory per synchronized write pointer
- rd_data  out  DATA_SIZE  registered output word
- rd_valid  out  1  rd_data holds a word
- rd_ready  in  1  consumer accepts rd_data this cycle

## Operation
- Synchronizer: two rd_clk flops, wq1 <= wr_ptr_gray, wq2 <= wq1. No other logic samples wr_ptr_gray.
- Pointers: binary rbin and Gray rgray = rbin ^ (rbin >> 1), both ADDR_SIZE+1 bits and registered. rd_addr = rbin[ADDR_SIZE-1:0]. rd_ptr_gray = rgray.
- fetch = !rd_empty && (!rd_valid || rd_ready).
- rbin_next = rbin + fetch, modulo 2^(ADDR_SIZE+1). rgray_next is the Gray code of rbin_next.
- rd_empty <= (rgray_next == wq2).
- rd_count <= gray2bin(wq2) - rbin_next, modulo 2^(ADDR_SIZE+1). Range is 0..2^ADDR_SIZE.
- Output stage, evaluated each edge:
  - If fetch: rd_data <= mem_rd_data and rd_valid <= 1.
  - Else if rd_valid && rd_ready: rd_valid <= 0.
  - Otherwise rd_data and rd_valid hold.
- Handshake:
  - A word transfers on an edge where rd_valid && rd_ready.
  - rd_data must remain stable while rd_valid && !rd_ready.
  - rd_ready is ignored while rd_valid = 0.
- Simultaneous accept and fetch: a new word loads, and rd_valid stays 1. This gives full throughput of one word per cycle.
- Empty with an accept: rd_valid drops; the pointer does not move.
- Wrap-around: the pointer runs 2^(ADDR_SIZE+1)-1 → 0, and the Gray code wraps with a single-bit change. The memory address wraps every 2^ADDR_SIZE words.
- Reset, asynchronous and immediate, including mid-burst:
  - rbin, rgray, wq1, wq2 = 0
  - rd_empty = 1, rd_count = 0
  - rd_valid = 0, rd_data = 0
  - Any word in the output stage is discarded.
  - Deassertion is applied synchronously to rd_clk by the top level.

## Timing
- Write pointer propagation. Let E0 be the edge at which wq1 captures a new wr_ptr_gray:
  - E1: wq2 updates.
  - E2: rd_empty falls and rd_count updates.
  - E3: first fetch; rd_valid = 1, rd_data valid, rd_addr and rd_ptr_gray advance.
- Back-to-back: with rd_ready held at 1 and the memory non-empty, one word transfers per edge.
- rd_ptr_gray changes at most one bit per edge and is glitch-free (registered).
- rd_empty and rd_count are conservative: they lag write activity by the synchronizer delay, never leading it.

## Test plan
- Reset: assert rd_rst_n=0 mid-clock. Required immediately, without a clock edge:
  - rd_valid=0, rd_empty=1, rd_count=0, rd_data=0, rd_addr=0, rd_ptr_gray=00000.
- Single word (ADDR_SIZE=4, DATA_SIZE=8): mem[0]=8'hA5, rd_ready=0, wr_ptr_gray 00000→00001. Required:
  - rd_valid=1 and rd_data=A5 at E3.
  - rd_addr=1, rd_ptr_gray=00001, rd_empty=1, rd_count=0.
  - rd_data holds A5 until rd_ready is asserted; rd_valid drops on the accepting edge.
- Full burst: 16 words 0x00..0x0F, wr_ptr_gray stepped to binary 16 (11000), rd_ready=1. Required:
  - rd_count=16 at E2.
  - 16 consecutive rd_valid cycles, data 0x00..0x0F in order.
  - Then rd_empty=1, rd_count=0, rd_ptr_gray=11000.
- Backpressure: during a burst, toggle rd_ready in the pattern 1,0,0,1. Required:
  - rd_data is stable while rd_ready=0.
  - rd_addr does not advance.
  - No word is lost or duplicated.
- Wrap: stream 40 words with the write pointer stepped in Gray code. Required:
  - The pointer passes binary 31→0 (Gray 10000→00000).
  - rd_addr wraps 15→0.
  - All 40 words arrive in order.
- Reset mid-burst: assert rd_rst_n with 5 words pending and rd_valid=1. Required:
  - All outputs take their reset values immediately.
  - After release with wr_ptr_gray=00000, rd_valid stays 0.
